one_hot_rr_arbiter: RTL and testbench
=====================================

# one_hot_rr_arbiter

Round-robin burst arbiter that shares the one-hot mux datapath between IN_NUM requesters. It drives the mux one-hot select (`sel`) directly and holds a grant for a whole burst, ending on the granted requester's `in_last` beat. It relays the valid/ready handshake between the granted requester and the single downstream consumer. A stall timeout frees the grant if the owner goes silent mid-burst.

## Interface
- IN_NUM, 4, number of requesters (≥2)
- TIMEOUT, 16, consecutive granted-but-idle cycles before forced release (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  IN_NUM  per-requester beat valid
- in_last  in  IN_NUM  per-requester final-beat marker, qualified by in_valid
- in_ready  out  IN_NUM  per-requester beat accept
- out_valid  out  1  downstream beat valid
- out_last  out  1  downstream final-beat marker
- out_ready  in  1  downstream accept
- sel  out  IN_NUM  registered one-hot mux select; all-zero when no grant
- busy  out  1  a grant is held (`sel` ≠ 0)
- err_timeout  out  1  one-cycle pulse on forced release

## Operation
- The FSM has two states, IDLE and GRANT. It also holds a round-robin pointer `ptr` (clog2(IN_NUM) bits) and a stall counter `hold_cnt` (clog2(TIMEOUT+1) bits).
- **Pick:** among set `in_valid` bits, take the first one at or after index `ptr`, wrapping modulo IN_NUM.
- **IDLE:** if any `in_valid` is set, register `sel` = one-hot(pick), clear `hold_cnt`, and go to GRANT. Otherwise stay in IDLE with `sel` = 0.
- **GRANT** (g = index of `sel`):
  - `in_ready[g]` = `out_ready`; all other `in_ready` bits are 0.
  - `out_valid` = `in_valid[g]`; `out_last` = `in_valid[g] & in_last[g]`.
  - A beat transfers when `in_valid[g] & out_ready`.
- **Release:** triggered by a beat with `in_last[g]` set.
  - Set `ptr` = (g+1) mod IN_NUM.
  - In the same cycle, evaluate pick with the new pointer, excluding g. If a winner exists, load `sel` with it and stay in GRANT (back-to-back bursts, no bubble). Otherwise set `sel` = 0 and go to IDLE.
- **Stall counter:** in GRANT, `hold_cnt` increments on each cycle with `in_valid[g]` = 0 and clears on each cycle with `in_valid[g]` = 1. A downstream stall (`in_valid[g]=1`, `out_ready=0`) does not count.
- **Timeout:** when `hold_cnt` reaches TIMEOUT, perform a forced release. It behaves like a normal release (pointer advance, re-pick excluding g), and additionally pulses `err_timeout` for one cycle. No beat is forwarded in that cycle.
- A single requester re-requesting after its own release is granted again only when no other requester is valid. This gives fairness: each other valid requester waits at most IN_NUM−1 bursts.
- IDLE produces no handshakes: `in_ready` = 0 and `out_valid` = 0.

## Timing
- **Reset values:** state = IDLE, `ptr` = 0, `hold_cnt` = 0, `sel` = 0, `busy` = 0, `err_timeout` = 0. `in_ready`, `out_valid` and `out_last` are 0 as a combinational consequence.
- **Arbitration latency:** `in_valid` is sampled in IDLE at edge t, and `sel` and `in_ready` are active from cycle t+1. The first beat can therefore transfer in cycle t+1.
- **Re-grant latency:** zero bubble. The release beat is at cycle t, and the next owner's `sel` is active at t+1.
- `sel` and `busy` are registers. `in_ready`, `out_valid` and `out_last` are combinational from `sel` and the live inputs. No combinational path exists from `out_ready` to `sel` within the same cycle.
- **Reset mid-burst:** the grant is dropped at the next edge, with no `err_timeout` and no pointer advance beyond its reset value.
- **Last beat stalled by out_ready=0:** the grant is held with no timeout, because the requester is valid.
- **`in_valid[g]` dropping mid-burst:** this is legal. The grant is held until `in_last` arrives or the timeout fires.

## Structure
- Package `arb_pkg` contains:
  - the `arb_state_e` enum {IDLE, GRANT}
  - the function `rr_pick(req, ptr, excl)` returning a one-hot vector
  - the helper `onehot_to_idx`
- One natural combinational sub-module is `rr_priority_pick` (parameter IN_NUM; inputs req, ptr, excl_mask; outputs one-hot gnt and a valid flag). It is instantiated once and used both for IDLE pick and for release re-pick.
- The data mux stays external. `sel` connects to its select input.

## Test plan
- **Reset then single request:** apply `in_valid` = 4'b0100 at cycle 3. Expect `sel` = 4'b0100 at cycle 4. A 3-beat burst with `out_ready` = 1 ends with `out_last` at cycle 6, then `sel` = 0 and `ptr` = 3.
- **All four requesting continuously with 1-beat bursts:** expect `sel` to rotate 0001 → 0010 → 0100 → 1000 → 0001 with no idle cycles.
- **Owner idle mid-burst with TIMEOUT = 4:** after 4 cycles of `in_valid[1]` = 0, expect `err_timeout` = 1 for one cycle. The grant moves to requester 2 if it is valid, otherwise `sel` = 0.
- **Downstream stall:** with `out_ready` = 0 for 20 cycles while `in_valid[g]` = 1, expect no timeout, `sel` stable and `in_ready[g]` = 0.
- **Reset asserted mid-burst:** expect `sel` = 0, `busy` = 0, `ptr` = 0 on the next cycle, and arbitration restarting from requester 0.
- **Requester 0 re-requesting immediately with requester 3 also valid:** after requester 0's last beat, expect `sel` = 1000.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and helpers for the one-hot round-robin burst
//               arbiter: FSM state encoding, a rotating priority pick and a
//               one-hot to index conversion. The helpers work on a fixed
//               maximum width (ARB_MAX_N requesters) so that any arbiter size
//               up to that bound can reuse them.
// Contents    : arb_state_e    - arbiter FSM states
//               rr_pick        - first set request at/after a pointer, wrapping
//               onehot_to_idx  - binary index of a one-hot vector
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int unsigned ARB_MAX_N = 32;
  localparam int unsigned ARB_IDX_W = 5;
  localparam int unsigned ARB_NUM_W = ARB_IDX_W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Scans n positions starting at ptr (wrapping at n) and returns a one-hot
  // vector for the first requester that is set in req and not set in excl.
  // Returns all zeros if nothing qualifies. ptr must be below n.
  function automatic logic [ARB_MAX_N-1:0] rr_pick(
    input logic [ARB_MAX_N-1:0] req,
    input logic [ARB_IDX_W-1:0] ptr,
    input logic [ARB_MAX_N-1:0] excl,
    input logic [ARB_NUM_W-1:0] n
  );
    logic [ARB_MAX_N-1:0] gnt;
    logic                 found;
    logic [ARB_NUM_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < ARB_MAX_N; k++) begin
      // ptr < n and k < n, so a single subtraction is enough to wrap.
      idx = {1'b0, ptr} + k[ARB_NUM_W-1:0];
      if (idx >= n) begin
        idx = idx - n;
      end
      if (!found && (k[ARB_NUM_W-1:0] < n) &&
          req[idx[ARB_IDX_W-1:0]] && !excl[idx[ARB_IDX_W-1:0]]) begin
        gnt[idx[ARB_IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
    return gnt;
  endfunction

  // OR-reduction of the indices of all set bits; exact for one-hot input,
  // zero for an all-zero input.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(
    input logic [ARB_MAX_N-1:0] oh
  );
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < ARB_MAX_N; k++) begin
      if (oh[k]) begin
        idx = idx | k[ARB_IDX_W-1:0];
      end
    end
    return idx;
  endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational rotating-priority picker. Selects the first
//               requester at or after i_ptr (wrapping modulo IN_NUM) that is
//               requesting and not masked out.
// Ports       : i_req       [IN_NUM] request vector
//               i_ptr       [PTR_W]  highest-priority index
//               i_excl_mask [IN_NUM] requesters excluded from this pick
//               o_gnt       [IN_NUM] one-hot winner, zero if none
//               o_valid     1        a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
  parameter int IN_NUM = 4,
  parameter int PTR_W  = $clog2(IN_NUM)
) (
  input  logic [IN_NUM-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  input  logic [IN_NUM-1:0] i_excl_mask,
  output logic [IN_NUM-1:0] o_gnt,
  output logic              o_valid
);

  import arb_pkg::*;

  localparam logic [ARB_NUM_W-1:0] c_N = ARB_NUM_W'(IN_NUM);

  logic [ARB_MAX_N-1:0] w_req_ext;
  logic [ARB_MAX_N-1:0] w_excl_ext;
  logic [ARB_IDX_W-1:0] w_ptr_ext;
  logic [ARB_MAX_N-1:0] w_gnt_ext;

  // Zero-extend to the helper's fixed width.
  always_comb begin
    w_req_ext                = '0;
    w_req_ext[IN_NUM-1:0]    = i_req;
    w_excl_ext               = '0;
    w_excl_ext[IN_NUM-1:0]   = i_excl_mask;
    w_ptr_ext                = '0;
    w_ptr_ext[PTR_W-1:0]     = i_ptr;
  end

  assign w_gnt_ext = rr_pick(w_req_ext, w_ptr_ext, w_excl_ext, c_N);
  assign o_gnt     = w_gnt_ext[IN_NUM-1:0];
  assign o_valid   = |w_gnt_ext[IN_NUM-1:0];

  // Positions above IN_NUM are never requested, so the pick never sets them.
  generate
    if (IN_NUM < ARB_MAX_N) begin : g_gnt_hi
      logic w_unused_gnt_hi;
      assign w_unused_gnt_hi = |w_gnt_ext[ARB_MAX_N-1:IN_NUM];
    end
  endgenerate

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/one_hot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_rr_arbiter
// Description : Round-robin burst arbiter driving the select of an external
//               one-hot data mux. A grant is held for a whole burst and ends
//               on the owner's last beat; the next owner is picked in the same
//               cycle so consecutive bursts run without a bubble. A stall
//               timeout releases an owner that stops presenting data.
// Ports       : clk          clock, rising edge
//               rst          synchronous active-high reset
//               in_valid     [IN_NUM] per-requester beat valid
//               in_last      [IN_NUM] per-requester final-beat marker
//               in_ready     [IN_NUM] per-requester beat accept
//               out_valid    downstream beat valid
//               out_last     downstream final-beat marker
//               out_ready    downstream accept
//               sel          [IN_NUM] registered one-hot mux select
//               busy         a grant is held
//               err_timeout  one-cycle pulse after a forced release
// Revision    : 1.0 - initial release
// ============================================================================
module one_hot_rr_arbiter #(
  parameter int IN_NUM  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_NUM-1:0] in_valid,
  input  logic [IN_NUM-1:0] in_last,
  output logic [IN_NUM-1:0] in_ready,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [IN_NUM-1:0] sel,
  output logic              busy,
  output logic              err_timeout
);

  import arb_pkg::*;

  localparam int PTR_W = $clog2(IN_NUM);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(IN_NUM - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [IN_NUM-1:0] r_sel;
  logic              r_busy;
  logic              r_err_timeout;

  arb_state_e        w_state_nxt;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IN_NUM-1:0] w_sel_nxt;

  // --------------------------------------------------------------------------
  // Owner decode
  // --------------------------------------------------------------------------
  logic [ARB_MAX_N-1:0] w_sel_ext;
  logic [ARB_IDX_W-1:0] w_g_idx_full;
  logic [PTR_W-1:0]     w_g_idx;
  logic [PTR_W-1:0]     w_ptr_adv;
  logic                 w_granted;
  logic                 w_own_valid;
  logic                 w_own_last;
  logic                 w_timeout;
  logic                 w_fwd_en;
  logic                 w_beat;
  logic                 w_release;

  always_comb begin
    w_sel_ext             = '0;
    w_sel_ext[IN_NUM-1:0] = r_sel;
  end

  assign w_g_idx_full = onehot_to_idx(w_sel_ext);
  assign w_g_idx      = w_g_idx_full[PTR_W-1:0];

  generate
    if (PTR_W < ARB_IDX_W) begin : g_idx_hi
      logic w_unused_idx_hi;
      assign w_unused_idx_hi = |w_g_idx_full[ARB_IDX_W-1:PTR_W];
    end
  endgenerate

  // Pointer moves one past the current owner, wrapping for non-power-of-2 N.
  assign w_ptr_adv = (w_g_idx == c_LAST_IDX) ? '0 : (w_g_idx + PTR_W'(1));

  assign w_granted   = (r_state == GRANT);
  assign w_own_valid = |(in_valid & r_sel);
  assign w_own_last  = |(in_valid & in_last & r_sel);

  // The forced-release cycle forwards nothing, even if the owner woke up.
  assign w_timeout = w_granted && (r_hold_cnt == c_TIMEOUT);
  assign w_fwd_en  = w_granted && !w_timeout;
  assign w_beat    = w_fwd_en && w_own_valid && out_ready;
  assign w_release = w_timeout || (w_beat && w_own_last);

  // --------------------------------------------------------------------------
  // Handshake relay (combinational from r_sel and live inputs)
  // --------------------------------------------------------------------------
  assign in_ready  = w_fwd_en ? (r_sel & {IN_NUM{out_ready}}) : '0;
  assign out_valid = w_fwd_en && w_own_valid;
  assign out_last  = w_fwd_en && w_own_last;

  // --------------------------------------------------------------------------
  // Shared picker: IDLE uses the stored pointer with no exclusion; GRANT
  // pre-computes the re-pick for a release this cycle, excluding the owner.
  // Its inputs never depend on out_ready.
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]  w_pick_ptr;
  logic [IN_NUM-1:0] w_pick_excl;
  logic [IN_NUM-1:0] w_pick_gnt;
  logic              w_pick_valid;

  assign w_pick_ptr  = w_granted ? w_ptr_adv : r_ptr;
  assign w_pick_excl = w_granted ? r_sel : '0;

  rr_priority_pick #(
    .IN_NUM (IN_NUM),
    .PTR_W  (PTR_W)
  ) u_pick (
    .i_req       (in_valid),
    .i_ptr       (w_pick_ptr),
    .i_excl_mask (w_pick_excl),
    .o_gnt       (w_pick_gnt),
    .o_valid     (w_pick_valid)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_hold_cnt;
    w_sel_nxt   = r_sel;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_pick_valid) begin
          w_sel_nxt   = w_pick_gnt;
          w_state_nxt = GRANT;
        end else begin
          w_sel_nxt = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_ptr_adv;
          w_cnt_nxt = '0;
          if (w_pick_valid) begin
            w_sel_nxt = w_pick_gnt;
          end else begin
            w_sel_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end else if (w_own_valid) begin
          // A present owner is never idle, even if downstream stalls it.
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_hold_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_sel         <= '0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_hold_cnt    <= w_cnt_nxt;
      r_sel         <= w_sel_nxt;
      r_busy        <= |w_sel_nxt;
      r_err_timeout <= w_timeout;
    end
  end

  assign sel         = r_sel;
  assign busy        = r_busy;
  assign err_timeout = r_err_timeout;

endmodule : one_hot_rr_arbiter
`default_nettype wire

// File: tb/tb_one_hot_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_one_hot_rr_arbiter
// Description : Directed, table-driven bench for one_hot_rr_arbiter with
//               IN_NUM=4 and TIMEOUT=4. Each record gives the inputs applied
//               during one cycle and the outputs expected in that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_one_hot_rr_arbiter;

  localparam int N  = 4;
  localparam int TO = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_last;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic [N-1:0] sel;
  logic         busy;
  logic         err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  one_hot_rr_arbiter #(
    .IN_NUM  (N),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .sel         (sel),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic         rst;
    logic [N-1:0] vld;
    logic [N-1:0] lst;
    logic         ordy;
    logic [N-1:0] sel;
    logic         busy;
    logic [N-1:0] rdy;
    logic         ov;
    logic         ol;
    logic         err;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic o,
    input logic [N-1:0] s, input logic b, input logic [N-1:0] rd,
    input logic ov, input logic ol, input logic er
  );
    vec_t t;
    t.rst = r;  t.vld = v;  t.lst = l;  t.ordy = o;
    t.sel = s;  t.busy = b; t.rdy = rd; t.ov = ov; t.ol = ol; t.err = er;
    return t;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled one
  // unit later, well away from the next edge.
  task automatic run_vec(input vec_t t, input string name);
    logic [3*N+3:0] exp_o;
    logic [3*N+3:0] act_o;
    @(posedge clk);
    #1;
    rst       = t.rst;
    in_valid  = t.vld;
    in_last   = t.lst;
    out_ready = t.ordy;
    #1;
    exp_o = {t.sel, t.busy, t.rdy, t.ov, t.ol, t.err};
    act_o = {sel, busy, in_ready, out_valid, out_last, err_timeout};
    n_checks++;
    if (act_o !== exp_o) begin
      n_fail++;
      $display("FAIL %s: got sel=%b busy=%b rdy=%b ov=%b ol=%b err=%b, expected sel=%b busy=%b rdy=%b ov=%b ol=%b err=%b",
               name, sel, busy, in_ready, out_valid, out_last, err_timeout,
               t.sel, t.busy, t.rdy, t.ov, t.ol, t.err);
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;

    //                  rst vld      lst      rdy  sel     bsy in_rdy  ov ol err
    // Reset state, then a 3-beat burst from requester 2.
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 4'b0100, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    // ptr is now 3: requester 3 beats requester 0, then 0 follows with no bubble.
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1001, 4'b1000, 1, 4'b1000, 1, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 4'b0001, 1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    // All four requesting 1-beat bursts, ptr starts at 1.
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 4'b0100, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 4'b1000, 1, 1, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b0001, 1, 1, 0));
    // Owner 1 goes silent for TIMEOUT cycles; the release cycle blocks its beat.
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 4'b0010, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0110, 4'b0000, 1, 4'b0010, 1, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1, 0, 1));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 4'b0000, 1, 0, 0));

    repeat (3) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("table[%0d]", i));
    end

    // Downstream stall with the owner valid: never counts towards timeout.
    for (int i = 0; i < 20; i++) begin
      run_vec(mk(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 4'b0000, 1, 0, 0),
              $sformatf("stall[%0d]", i));
    end
    // Last beat held back by downstream.
    for (int i = 0; i < 6; i++) begin
      run_vec(mk(0, 4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0000, 1, 1, 0),
              $sformatf("last_stall[%0d]", i));
    end
    run_vec(mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 1, 4'b0100, 1, 1, 0), "last_accept");
    run_vec(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0), "idle_after_stall");

    // Timeout with nobody else waiting: ptr=3 wraps to requester 0.
    run_vec(mk(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0), "to_req");
    for (int i = 0; i < TO; i++) begin
      run_vec(mk(0, 4'b0000, 4'b0000, 1, 4'b0001, 1, 4'b0001, 0, 0, 0),
              $sformatf("to_idle[%0d]", i));
    end
    run_vec(mk(0, 4'b0000, 4'b0000, 1, 4'b0001, 1, 4'b0000, 0, 0, 0), "to_release");
    run_vec(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 1), "to_pulse");
    run_vec(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0), "to_pulse_end");

    // Reset in the middle of a burst (ptr=1 beforehand).
    run_vec(mk(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0), "rst_req");
    run_vec(mk(0, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1, 0, 0), "rst_beat");
    run_vec(mk(1, 4'b0100, 4'b0000, 1, 4'b0100, 1, 4'b0100, 1, 0, 0), "rst_assert");
    run_vec(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0), "rst_dropped");
    run_vec(mk(0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0), "rst_rearb");

    // Requester 0 re-requests at once while 3 waits: 3 wins. Owner 3 has
    // short idle gaps that must not accumulate into a timeout.
    run_vec(mk(0, 4'b1001, 4'b0001, 1, 4'b0001, 1, 4'b0001, 1, 1, 0), "rr_ptr0");
    run_vec(mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 4'b1000, 1, 0, 0), "rr_to3");
    for (int i = 0; i < 3; i++) begin
      run_vec(mk(0, 4'b0001, 4'b0000, 1, 4'b1000, 1, 4'b1000, 0, 0, 0),
              $sformatf("gap_a[%0d]", i));
    end
    run_vec(mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 1, 4'b1000, 1, 0, 0), "gap_beat");
    for (int i = 0; i < 3; i++) begin
      run_vec(mk(0, 4'b0001, 4'b0000, 1, 4'b1000, 1, 4'b1000, 0, 0, 0),
              $sformatf("gap_b[%0d]", i));
    end
    run_vec(mk(0, 4'b1001, 4'b1000, 1, 4'b1000, 1, 4'b1000, 1, 1, 0), "rr3_last");
    run_vec(mk(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 4'b0001, 1, 1, 0), "rr0_last");
    run_vec(mk(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000, 0, 0, 0), "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_one_hot_rr_arbiter
`default_nettype wire
